inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage directly upstream of the MIPS core's decode/execute logic. It owns the program counter, issues word fetches to a variable-latency instruction memory over a request/grant/response interface, and buffers returned instructions in a small prefetch queue. Each instruction is presented to the core with its PC over a valid/ready handshake. Branch, jump and `jr` targets resolved by the core arrive as a redirect, which flushes the queue and discards stale in-flight responses.

## Interface
- `DEPTH`, default 4: prefetch queue entries and the cap on in-flight requests; power of 2, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, **asynchronous, active-high** despite the name.
- `imem_req`  out  1: fetch request this cycle.
- `imem_addr`  out  32: fetch byte address; bits [1:0] always 0.
- `imem_gnt`  in  1: memory accepts the request in the same cycle.
- `imem_rvalid`  in  1: response valid; responses return in request order, at least 1 cycle after grant.
- `imem_rdata`  in  32: instruction word.
- `redirect_valid`  in  1: core requests a change of flow.
- `redirect_pc`  in  32: target address; bits [1:0] ignored.
- `if_valid`  out  1: `if_ir` and `if_pc` are valid.
- `if_ready`  in  1: core consumes the head entry when `if_valid` is high.
- `if_ir`  out  32: instruction word.
- `if_pc`  out  32: address of `if_ir`.

## Operation
- State: `fetch_pc`, `resp_pc`, `outstanding` (0..DEPTH), `discard` (0..`outstanding`), and a queue of {pc, ir} entries with `count` (0..DEPTH).
- Issue: `imem_req` = !`redirect_valid` && (`outstanding` + `count` < DEPTH). `imem_addr` = `fetch_pc`. On `imem_req` && `imem_gnt`: `fetch_pc` += 4 (wraps mod 2^32), and `outstanding` increments.
- Response: on `imem_rvalid`, `outstanding` decrements. If `discard` > 0, `discard` decrements and the data is dropped. Otherwise {`resp_pc`, `imem_rdata`} is pushed and `resp_pc` += 4.
- Credit rule: the queue can never overflow, because every granted request has a reserved slot.
- Output: `if_valid` = (`count` != 0) && !`redirect_valid`. Head entry drives `if_pc`/`if_ir`. A pop occurs on `if_valid` && `if_ready`.
- Push and pop in the same cycle are allowed, including when `count` is DEPTH-1, DEPTH, or 1.
- Redirect (priority over everything):
  - queue flushed, so `count` becomes 0 and no pop occurs;
  - `fetch_pc` and `resp_pc` both become {`redirect_pc`[31:2], 2'b00};
  - `discard` becomes the next value of `outstanding`, counting all old-path requests still in flight after this cycle;
  - any `imem_rvalid` arriving this cycle is dropped.
- Back-to-back redirects: the last one wins, and `discard` is recomputed each time.
- `imem_rvalid` while `outstanding` == 0 is a protocol violation; it is ignored and state is unchanged.

## Timing
- Reset values:
  - `imem_req` 0 and `if_valid` 0 while `rst_n` is high;
  - `fetch_pc` and `resp_pc` = RESET_PC;
  - `outstanding`, `discard` and `count` = 0;
  - `if_ir` and `if_pc` = 0.
- Reset mid-operation aborts everything. Responses to pre-reset requests are the memory model's responsibility; the bench must not send them.
- First `imem_req` in the first cycle after `rst_n` falls.
- Latency with a 1-cycle memory: grant at cycle t, rvalid at t+1, push at the end of t+1, `if_valid` at t+2.
- Redirect at t: `imem_req` is low at t and the new-path request goes out at t+1. With no stale requests, the earliest `if_valid` is at t+3.
- Steady state with a 1-cycle memory and `if_ready` held high: one instruction per cycle.
- `if_valid`/`if_pc`/`if_ir` depend only on registered state, except the combinational mask from `redirect_valid`. `imem_req` depends on `redirect_valid` combinationally.

## Structure
- Package `fetch_pkg`: `DEPTH`/`RESET_PC` defaults, `WORD_W`=32, and a `fetch_entry_t` struct {pc, ir}.
- Sub-module `fetch_queue`: synchronous FIFO with a flush input, parameterised by DEPTH. It exposes `count`, push, pop, and the head entry.
- The top level holds the PC registers, the `outstanding`/`discard` counters and the issue logic.

## Test plan
- Reset, then a 1-cycle memory returning word = address, with `if_ready`=1: first `if_pc`=0x0 at cycle 2 after reset release, then 0x4, 0x8 on consecutive cycles, each with `if_ir`=`if_pc`.
- `if_ready`=0 held with DEPTH=4: exactly 4 grants, then `imem_req` stays low and `count`=4. Raising `if_ready` drains 0x0, 0x4, 0x8, 0xC in order, and issue resumes at 0x10.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x100: the 3 stale responses are dropped, and the first `if_pc` is 0x100 with the correct word.
- Redirect in the same cycle as `imem_rvalid` and a pop: the queue is empty next cycle, no old-path instruction is ever presented, and fetch resumes at the target.
- Two redirects on consecutive cycles (0x200 then 0x300): only the 0x300 stream appears, and `discard` accounts for the grant made between the two.
- Async reset asserted mid-stream with the queue full: `if_valid` and `imem_req` drop immediately without a clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Queue entries carry the fetch address alongside the returned instruction word.
package fetch_pkg;

  localparam int          WORD_W           = 32;
  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, ir} entries with single-cycle flush.
// The head entry is read combinationally; push and pop may coincide even when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     entry_q [DEPTH];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      fetch_entry_t data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          data_reg <= push_entry;
        end
      end

      assign entry_q[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = entry_q[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// in-order response capture into the prefetch queue, and redirect handling.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_ir,
  output logic [WORD_W-1:0] if_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WORD_W-1:0] fetch_pc_reg;
  logic [WORD_W-1:0] fetch_pc_next;
  logic [WORD_W-1:0] resp_pc_reg;
  logic [WORD_W-1:0] resp_pc_next;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  discard_reg;
  logic [CNT_W-1:0]  discard_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              resp_fire;
  logic              resp_keep;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  // Every granted request owns a queue slot until its response is consumed.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, count};
  assign imem_req    = !rst_n && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc_reg;
  assign grant       = imem_req && imem_gnt;

  // A response with nothing outstanding is spurious and leaves all state alone.
  assign resp_fire = imem_rvalid && (outstanding_reg != '0);
  assign resp_keep = resp_fire && !redirect_valid && (discard_reg == '0);

  assign if_valid = (count != '0) && !redirect_valid;
  assign pop      = if_valid && if_ready;
  assign if_pc    = head.pc;
  assign if_ir    = head.ir;

  assign push_entry.pc = resp_pc_reg;
  assign push_entry.ir = imem_rdata;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;

    if (grant) begin
      outstanding_next = outstanding_next + CNT_W'(1);
    end
    if (resp_fire) begin
      outstanding_next = outstanding_next - CNT_W'(1);
    end

    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_next = word_align(redirect_pc);
      resp_pc_next  = word_align(redirect_pc);
      discard_next  = outstanding_next;
    end else begin
      if (grant) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (resp_fire) begin
        if (discard_reg != '0) begin
          discard_next = discard_reg - CNT_W'(1);
        end else begin
          resp_pc_next = resp_pc_reg + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst_n),
    .flush      (redirect_valid),
    .push       (resp_keep),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue/epoch transaction model of the fetch stage.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt       = 1'b0;
  logic        imem_rvalid    = 1'b0;
  logic [31:0] imem_rdata     = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        if_valid;
  logic        if_ready       = 1'b0;
  logic [31:0] if_ir;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_pc          (if_pc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int spur_pct = 0;
  logic [31:0] salt = '0;

  // memory environment: outstanding requests with their due cycle
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t pend[$];

  // reference model: requests tagged with the path epoch they belong to
  typedef struct { logic [31:0] addr; int epoch; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  flight_t     inflight[$];
  ent_t        fq[$];
  logic [31:0] m_fetch_pc;
  int          m_epoch;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_ir;

  typedef struct {
    logic        rst_before;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return addr ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    inflight.delete();
    fq.delete();
    m_fetch_pc = RESET_PC;
    m_epoch    = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc, input logic gnt);
    logic        rv, e_req, e_valid, grant, pop;
    logic [31:0] rd;
    flight_t     f;
    rv = 1'b0;
    rd = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = word_of(pend[0].addr);
    end else if (pend.size() == 0 && spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
      rv = 1'b1;
      rd = $urandom;
    end
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = if_valid;
    obs_pc    = if_pc;
    obs_ir    = if_ir;

    e_req   = !redir && (inflight.size() + fq.size() < DEPTH);
    e_valid = (fq.size() != 0) && !redir;
    chk("imem_req", 32'(obs_req), 32'(e_req));
    chk("imem_addr", obs_addr, m_fetch_pc);
    chk("if_valid", 32'(obs_valid), 32'(e_valid));
    if (e_valid) begin
      chk("if_pc", obs_pc, fq[0].pc);
      chk("if_ir", obs_ir, fq[0].ir);
    end

    grant = e_req && gnt;
    pop   = e_valid && rdy;
    if (rv && pend.size() != 0) void'(pend.pop_front());
    if (grant) pend.push_back('{m_fetch_pc, cyc + int'($urandom_range(lat_min, lat_max))});

    if (redir) begin
      if (rv && inflight.size() != 0) void'(inflight.pop_front());
      fq.delete();
      m_epoch++;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(fq.pop_front());
      if (rv && inflight.size() != 0) begin
        f = inflight.pop_front();
        if (f.epoch == m_epoch) fq.push_back('{f.addr, rd});
      end
      if (grant) begin
        inflight.push_back('{m_fetch_pc, m_epoch});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Called at a falling edge: reset asserts between clock edges.
  task automatic apply_reset();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if_ready       = 1'b0;
    #1;
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst imem_addr", imem_addr, RESET_PC);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_ir", if_ir, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc, input int budget,
                            output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      waited = i + 1;
      if (obs_valid) begin
        seen = 1'b1;
        chk(name, obs_pc, exp_pc);
        chk({name, " ir"}, obs_ir, word_of(exp_pc));
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no if_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic add_row(input logic rb, input logic rdy, input logic redir, input logic [31:0] rpc,
                         input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                         input logic [31:0] e_pc);
    tbl.push_back('{rb, rdy, redir, rpc, e_req, e_addr, e_valid, e_pc});
  endtask

  initial begin
    int waited;
    // startup with a 1-cycle memory and if_ready high, then a redirect to 0x40
    add_row(1, 1, 0, 32'h0,  1, 32'h00, 0, 32'h0);
    add_row(0, 1, 0, 32'h0,  1, 32'h04, 0, 32'h0);
    add_row(0, 1, 0, 32'h0,  1, 32'h08, 1, 32'h00);
    add_row(0, 1, 0, 32'h0,  1, 32'h0C, 1, 32'h04);
    add_row(0, 1, 0, 32'h0,  1, 32'h10, 1, 32'h08);
    add_row(0, 1, 0, 32'h0,  1, 32'h14, 1, 32'h0C);
    add_row(0, 1, 1, 32'h43, 0, 32'h18, 0, 32'h0);
    add_row(0, 1, 0, 32'h0,  1, 32'h40, 0, 32'h0);
    add_row(0, 1, 0, 32'h0,  1, 32'h44, 0, 32'h0);
    add_row(0, 1, 0, 32'h0,  1, 32'h48, 1, 32'h40);
    add_row(0, 1, 0, 32'h0,  1, 32'h4C, 1, 32'h44);
    // if_ready low: exactly DEPTH grants, then drain and resume at 0x10
    add_row(1, 0, 0, 32'h0,  1, 32'h00, 0, 32'h0);
    add_row(0, 0, 0, 32'h0,  1, 32'h04, 0, 32'h0);
    add_row(0, 0, 0, 32'h0,  1, 32'h08, 1, 32'h00);
    add_row(0, 0, 0, 32'h0,  1, 32'h0C, 1, 32'h00);
    add_row(0, 0, 0, 32'h0,  0, 32'h10, 1, 32'h00);
    add_row(0, 0, 0, 32'h0,  0, 32'h10, 1, 32'h00);
    add_row(0, 1, 0, 32'h0,  0, 32'h10, 1, 32'h00);
    add_row(0, 1, 0, 32'h0,  1, 32'h10, 1, 32'h04);
    add_row(0, 1, 0, 32'h0,  1, 32'h14, 1, 32'h08);
    add_row(0, 1, 0, 32'h0,  1, 32'h18, 1, 32'h0C);
    add_row(0, 1, 0, 32'h0,  1, 32'h1C, 1, 32'h10);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) apply_reset();
      cycle(tbl[i].rdy, tbl[i].redir, tbl[i].rpc, 1'b1);
      chk($sformatf("vec%0d imem_req", i), 32'(obs_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d imem_addr", i), obs_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d if_valid", i), 32'(obs_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d if_pc", i), obs_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d if_ir", i), obs_ir, tbl[i].e_pc);
      end
    end

    // 3-cycle memory, three requests in flight when redirecting to 0x100
    lat_min = 3; lat_max = 3;
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    chk("lat3 redirect req", 32'(obs_req), 32'd0);
    wait_first("lat3 first pc", 32'h100, 20, waited);
    chk("lat3 cycles to first", 32'(waited), 32'd5);
    repeat (6) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // redirect coinciding with a response and a would-be pop
    lat_min = 1; lat_max = 1;
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h400, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("redir+pop queue empty", 32'(obs_valid), 32'd0);
    chk("redir+pop new addr", obs_addr, 32'h400);
    wait_first("redir+pop first pc", 32'h400, 10, waited);
    chk("redir+pop cycles to first", 32'(waited), 32'd2);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // redirect, one grant on the new path, redirect again
    lat_min = 2; lat_max = 2;
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("double redir grant 0x200", obs_addr, 32'h200);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    wait_first("double redir first pc", 32'h300, 12, waited);
    chk("double redir cycles to first", 32'(waited), 32'd4);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h500, 1'b1);
    cycle(1'b1, 1'b1, 32'h600, 1'b1);
    wait_first("back-to-back redir first pc", 32'h600, 12, waited);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // async reset with a full queue, then restart at RESET_PC
    lat_min = 1; lat_max = 1;
    apply_reset();
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("full before reset valid", 32'(obs_valid), 32'd1);
    chk("full before reset req", 32'(obs_req), 32'd0);
    apply_reset();
    wait_first("restart first pc", RESET_PC, 8, waited);
    chk("restart cycles to first", 32'(waited), 32'd3);

    // randomized traffic, variable latency, spurious responses, wrapping targets
    salt     = 32'hC3A5_0000;
    lat_min  = 1;
    lat_max  = 4;
    spur_pct = 5;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      logic        rdy, redir, gnt;
      logic [31:0] rpc;
      rdy   = ($urandom_range(0, 9) < 6);
      gnt   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      if ($urandom_range(0, 599) == 0) apply_reset();
      cycle(rdy, redir, rpc, gnt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
